// File: rtl/cnn_pkg.sv
// Shared CNN layer types and constants: element type, feature-map dimensions,
// layer start/done FSM states and small helpers used by the pooling engine.
package cnn_pkg;

   localparam int DATA_W       = 32;
   localparam int CONV_OUT_DIM = 6;
   localparam int POOL_SIZE    = 2;
   localparam int POOL_OUT_DIM = CONV_OUT_DIM / POOL_SIZE;

   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } layer_state_e;

   // Counter/index width that stays at least one bit for degenerate sizes.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pool_window_addr_gen.sv
// Walks the pooling windows row-major (orow, ocol) and each window's elements
// row-major (wr, wc); produces the input/output indices and window markers.
module pool_window_addr_gen
   import cnn_pkg::*;
#(
   parameter int IN_DIM    = CONV_OUT_DIM,
   parameter int POOL      = POOL_SIZE,
   parameter int OUT_DIM   = IN_DIM / POOL,
   parameter int IN_IDX_W  = cnt_w(IN_DIM * IN_DIM),
   parameter int OUT_IDX_W = cnt_w(OUT_DIM * OUT_DIM)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 advance,
   output logic [IN_IDX_W-1:0]  in_idx,
   output logic [OUT_IDX_W-1:0] out_idx,
   output logic                 first_elem,
   output logic                 last_elem,
   output logic                 last_window
);

   localparam int WIN_W = cnt_w(POOL);
   localparam int POS_W = cnt_w(OUT_DIM);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(OUT_DIM - 1);

   logic [POS_W-1:0] orow_reg, orow_next;
   logic [POS_W-1:0] ocol_reg, ocol_next;
   logic [WIN_W-1:0] wr_reg, wr_next;
   logic [WIN_W-1:0] wc_reg, wc_next;

   always_ff @(posedge clk) begin
      if (!rst) begin
         orow_reg <= '0;
         ocol_reg <= '0;
         wr_reg   <= '0;
         wc_reg   <= '0;
      end else begin
         orow_reg <= orow_next;
         ocol_reg <= ocol_next;
         wr_reg   <= wr_next;
         wc_reg   <= wc_next;
      end
   end

   // Nested odometer: wc fastest, then wr, ocol, orow; wraps to zero at the end.
   always_comb begin
      orow_next = orow_reg;
      ocol_next = ocol_reg;
      wr_next   = wr_reg;
      wc_next   = wc_reg;
      if (clear) begin
         orow_next = '0;
         ocol_next = '0;
         wr_next   = '0;
         wc_next   = '0;
      end else if (advance) begin
         if (wc_reg != WIN_LAST) begin
            wc_next = wc_reg + 1'b1;
         end else begin
            wc_next = '0;
            if (wr_reg != WIN_LAST) begin
               wr_next = wr_reg + 1'b1;
            end else begin
               wr_next = '0;
               if (ocol_reg != POS_LAST) begin
                  ocol_next = ocol_reg + 1'b1;
               end else begin
                  ocol_next = '0;
                  orow_next = (orow_reg == POS_LAST) ? '0 : orow_reg + 1'b1;
               end
            end
         end
      end
   end

   assign in_idx = IN_IDX_W'((int'(orow_reg) * POOL + int'(wr_reg)) * IN_DIM
                             + int'(ocol_reg) * POOL + int'(wc_reg));
   assign out_idx     = OUT_IDX_W'(int'(orow_reg) * OUT_DIM + int'(ocol_reg));
   assign first_elem  = (wr_reg == '0) && (wc_reg == '0);
   assign last_elem   = (wr_reg == WIN_LAST) && (wc_reg == WIN_LAST);
   assign last_window = (orow_reg == POS_LAST) && (ocol_reg == POS_LAST);

endmodule

// File: rtl/maxpool_seq_engine.sv
// Sequential POOLxPOOL max-pool layer: one input element per cycle, start/done
// handshake. Define MAXPOOL_RELU_EN to clamp each pooled value at zero (fused ReLU).
module maxpool_seq_engine #(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int IN_DIM = cnn_pkg::CONV_OUT_DIM,
   parameter int POOL   = cnn_pkg::POOL_SIZE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] input_fm  [IN_DIM*IN_DIM],
   output logic signed [DATA_W-1:0] output_fm [(IN_DIM/POOL)*(IN_DIM/POOL)],
   output logic                     busy,
   output logic                     done
);

   import cnn_pkg::*;

   localparam int OUT_DIM   = IN_DIM / POOL;
   localparam int OUT_N     = OUT_DIM * OUT_DIM;
   localparam int IN_IDX_W  = cnt_w(IN_DIM * IN_DIM);
   localparam int OUT_IDX_W = cnt_w(OUT_N);

   generate
      if (IN_DIM % POOL != 0) begin : g_bad_dim
         $error("maxpool_seq_engine: IN_DIM must be a multiple of POOL");
      end
   endgenerate

   layer_state_e state_reg, state_next;

   logic signed [DATA_W-1:0] max_reg, max_next;
   logic signed [DATA_W-1:0] cur_elem, win_max, wr_val;
   logic                     busy_reg, done_reg;
   logic                     clear_cnt, advance_cnt, wr_en;
   logic [IN_IDX_W-1:0]      in_idx;
   logic [OUT_IDX_W-1:0]     out_idx;
   logic                     first_elem, last_elem, last_window;

   pool_window_addr_gen #(
      .IN_DIM   (IN_DIM),
      .POOL     (POOL),
      .OUT_DIM  (OUT_DIM),
      .IN_IDX_W (IN_IDX_W),
      .OUT_IDX_W(OUT_IDX_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear_cnt),
      .advance    (advance_cnt),
      .in_idx     (in_idx),
      .out_idx    (out_idx),
      .first_elem (first_elem),
      .last_elem  (last_elem),
      .last_window(last_window)
   );

   always_comb begin
      state_next  = state_reg;
      clear_cnt   = 1'b0;
      advance_cnt = 1'b0;
      wr_en       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = SCAN;
               clear_cnt  = 1'b1;
            end
         end
         SCAN: begin
            advance_cnt = 1'b1;
            wr_en       = last_elem;
            if (last_elem && last_window) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The first element of a window seeds the running max, so no sentinel minimum is needed.
   assign cur_elem = input_fm[in_idx];
   assign win_max  = (first_elem || (cur_elem > max_reg)) ? cur_elem : max_reg;
   assign max_next = (state_reg == SCAN) ? win_max : max_reg;

`ifdef MAXPOOL_RELU_EN
   assign wr_val = win_max[DATA_W-1] ? '0 : win_max;
`else
   assign wr_val = win_max;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         max_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         max_reg   <= max_next;
         busy_reg  <= (state_next != IDLE);
         done_reg  <= (state_next == DONE);
      end
   end

   // Entries are not cleared at start: each holds its value until its window is rewritten.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_N; gi++) begin : g_out
         logic signed [DATA_W-1:0] fm_reg;
         always_ff @(posedge clk) begin
            if (!rst) begin
               fm_reg <= '0;
            end else if (wr_en && (out_idx == OUT_IDX_W'(gi))) begin
               fm_reg <= wr_val;
            end
         end
         assign output_fm[gi] = fm_reg;
      end
   endgenerate

   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_maxpool_seq_engine.sv
// Randomized self-checking bench for maxpool_seq_engine against a loop-based
// max-pool reference model; one line printed per scan transaction.
module tb_maxpool_seq_engine;

   localparam int DW    = 32;
   localparam int ID    = 6;
   localparam int P     = 2;
   localparam int OD    = ID / P;
   localparam int N_IN  = ID * ID;
   localparam int N_OUT = OD * OD;
   localparam int LAT   = OD * OD * P * P + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic signed [DW-1:0] input_fm  [N_IN];
   logic signed [DW-1:0] output_fm [N_OUT];
   logic busy, done;

   logic signed [DW-1:0] exp_fm  [N_OUT];
   logic signed [DW-1:0] prev_fm [N_OUT];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   maxpool_seq_engine #(.DATA_W(DW), .IN_DIM(ID), .POOL(P)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .input_fm (input_fm),
      .output_fm(output_fm),
      .busy     (busy),
      .done     (done)
   );

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain max over each window, then optional ReLU clamp.
   function automatic void model();
      for (int orow = 0; orow < OD; orow++) begin
         for (int ocol = 0; ocol < OD; ocol++) begin
            longint m = input_fm[(orow * P) * ID + ocol * P];
            for (int r = 0; r < P; r++)
               for (int c = 0; c < P; c++)
                  if (input_fm[(orow * P + r) * ID + ocol * P + c] > m)
                     m = input_fm[(orow * P + r) * ID + ocol * P + c];
`ifdef MAXPOOL_RELU_EN
            if (m < 0) m = 0;
`endif
            exp_fm[orow * OD + ocol] = DW'(m);
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_const(input logic signed [DW-1:0] v);
      for (int i = 0; i < N_IN; i++) input_fm[i] = v;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < N_IN; i++) begin
         case ($urandom_range(0, 7))
            0:       input_fm[i] = 32'h8000_0000;
            1:       input_fm[i] = 32'h7fff_ffff;
            2:       input_fm[i] = -1;
            default: input_fm[i] = $urandom;
         endcase
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int i = 0; i < N_OUT; i++)
         check_eq($sformatf("%s_fm%0d", tag, i), output_fm[i], exp_fm[i]);
   endtask

   task automatic check_zero_outputs(input string tag);
      for (int i = 0; i < N_OUT; i++)
         check_eq($sformatf("%s_fm%0d", tag, i), output_fm[i], 0);
   endtask

   // Pulses start in the current cycle; ex_a/ex_b are edges (after the start edge)
   // that see an extra start pulse. Returns during the cycle in which done is high.
   task automatic run_scan(input string tag, input int ex_a, input int ex_b);
      int lat = -1;
      int bcnt = 0;
      model();
      start = 1'b1;
      step();
      start = 1'b0;
      if (busy) bcnt++;
      for (int k = 1; k <= 60; k++) begin
         start = (k == ex_a) || (k == ex_b);
         step();
         start = 1'b0;
         if (busy) bcnt++;
         if (done) begin
            lat = k + 1;  // edge at which done is captured
            break;
         end
      end
      check_eq({tag, "_latency"}, lat, LAT);
      check_eq({tag, "_busy_cycles"}, bcnt, LAT);
      check_outputs(tag);
      $display("scan %-8s: done at edge %0d, busy %0d cycles, fm0=%0d fm4=%0d fm8=%0d",
               tag, lat, bcnt, output_fm[0], output_fm[4], output_fm[8]);
   endtask

   initial begin
      int dcnt;
      int bcnt;
      bit seen;

      fill_const(0);
      repeat (3) step();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_zero_outputs("rst");
      rst = 1'b1;
      step();

      for (int i = 0; i < N_IN; i++) input_fm[i] = i;
      run_scan("ramp", 0, 0);
      step();
      check_eq("ramp_done_one_cycle", done, 0);
      check_eq("ramp_idle_busy", busy, 0);

      fill_const(-5);
      run_scan("neg5", 0, 0);
      step();

      fill_const(32'h8000_0000);
      input_fm[(1 * P + 0) * ID + 2 * P + 1] = -1;
      run_scan("minval", 0, 0);
      step();

      fill_rand();
      run_scan("xstart", 5, 20);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq($sformatf("noqueue_busy%0d", i), busy, 0);
         check_eq($sformatf("noqueue_done%0d", i), done, 0);
      end

      fill_rand();
      run_scan("b2b_a", 0, 0);
      step();
      check_eq("b2b_idle", busy, 0);
      fill_rand();
      run_scan("b2b_b", 0, 0);
      step();

      // Restarted pass shows stale entries until each window is rewritten.
      for (int i = 0; i < N_OUT; i++) prev_fm[i] = output_fm[i];
      fill_rand();
      model();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (P * P * 2) step();
      for (int i = 0; i < N_OUT; i++)
         check_eq($sformatf("stale_fm%0d", i), output_fm[i], (i < 2) ? exp_fm[i] : prev_fm[i]);
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         step();
         if (done) seen = 1'b1;
      end
      check_eq("stale_done_seen", seen, 1);
      check_outputs("stale_final");
      $display("scan stale   : partial-pass stale values checked, done seen=%0d", seen);
      step();

      fill_rand();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (14) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_zero_outputs("abort");
      dcnt = 0;
      bcnt = 0;
      for (int k = 0; k < 45; k++) begin
         step();
         if (done) dcnt++;
         if (busy) bcnt++;
      end
      check_eq("abort_no_done", dcnt, 0);
      check_eq("abort_stays_idle", bcnt, 0);
      $display("scan abort   : reset at edge 15, done pulses=%0d busy cycles=%0d", dcnt, bcnt);
      fill_rand();
      run_scan("post_rst", 0, 0);
      step();

      rst = 1'b0;
      start = 1'b1;
      step();
      rst = 1'b1;
      start = 1'b0;
      check_eq("rst_start_busy", busy, 0);
      step();
      check_eq("rst_start_idle", busy, 0);
      check_eq("rst_start_done", done, 0);
      $display("scan rststart: busy=%0d after reset+start edge", busy);

      for (int t = 0; t < 4; t++) begin
         fill_rand();
         run_scan($sformatf("rand%0d", t), 0, 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
